// File: rtl/axis_vec_pkg.sv
// Shared types for the AXI4-Stream vector transmitter: word type, FSM states, width helper.
package axis_vec_pkg;

   localparam int unsigned WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} tx_state_t;

   // Index width that stays legal for DEPTH == 1.
   function automatic int unsigned idx_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/axis_vec_buf.sv
// DEPTH x word_t register file: one write port gated off while busy, one combinational read port.
module axis_vec_buf
   import axis_vec_pkg::*;
#(
   parameter int unsigned DEPTH = 20,
   parameter int unsigned AW    = 5
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic          busy,
   input  logic [AW-1:0] wr_addr,
   input  word_t         wr_data,
   input  logic [AW-1:0] rd_addr,
   output word_t         rd_data
);

   // Contents intentionally have no reset so a loaded vector survives areset.
   word_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en && !busy && (32'(wr_addr) < DEPTH)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;

endmodule

// File: rtl/axis_vec_tx.sv
// AXI4-Stream vector transmitter: streams len buffered words with TLAST on the final beat.
// Optional transfer cycle counter enabled by defining AXIS_VEC_TX_PERF_EN.
module axis_vec_tx
   import axis_vec_pkg::*;
#(
   parameter int unsigned DEPTH = 20,
   localparam int unsigned AW   = idx_width(DEPTH),
   localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic [LW-1:0]     len,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              start_err,
   output logic [31:0]       cycles,
   output logic [WORD_W-1:0] OUTPUT_AXIS_TDATA,
   output logic              OUTPUT_AXIS_TLAST,
   output logic              OUTPUT_AXIS_TVALID,
   input  logic              OUTPUT_AXIS_TREADY
);

   tx_state_t     state_q;
   logic [AW-1:0] idx_q;
   logic [LW-1:0] len_q;
   logic          tvalid_q;
   logic          tlast_q;
   logic          busy_q;
   logic          done_q;
   logic          start_err_q;
   word_t         rd_data;
   logic          len_ok;
   logic          start_ok;
   logic          hs;

   assign len_ok   = (len != '0) && (len <= LW'(DEPTH));
   assign start_ok = (state_q == S_IDLE) && start && len_ok;
   assign hs       = tvalid_q && OUTPUT_AXIS_TREADY;

   axis_vec_buf #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_buf (
      .clk     (aclk),
      .wr_en   (wr_en),
      .busy    (busy_q),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (idx_q),
      .rd_data (rd_data)
   );

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         len_q       <= '0;
         tvalid_q    <= 1'b0;
         tlast_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         start_err_q <= 1'b0;
      end else begin
         done_q      <= 1'b0;
         start_err_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (len_ok) begin
                     len_q    <= len;
                     idx_q    <= '0;
                     tvalid_q <= 1'b1;
                     tlast_q  <= (len == LW'(1));
                     busy_q   <= 1'b1;
                     state_q  <= S_SEND;
                  end else begin
                     start_err_q <= 1'b1;
                  end
               end
            end
            S_SEND: begin
               if (hs) begin
                  if (tlast_q) begin
                     tvalid_q <= 1'b0;
                     tlast_q  <= 1'b0;
                     done_q   <= 1'b1;
                     state_q  <= S_DONE;
                  end else begin
                     idx_q   <= idx_q + AW'(1);
                     // Next beat is last when idx+1 == len_q-1.
                     tlast_q <= ((LW'(idx_q) + LW'(2)) == len_q);
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy               = busy_q;
   assign done               = done_q;
   assign start_err          = start_err_q;
   assign OUTPUT_AXIS_TVALID = tvalid_q;
   assign OUTPUT_AXIS_TLAST  = tlast_q;
   assign OUTPUT_AXIS_TDATA  = tvalid_q ? rd_data : '0;

`ifdef AXIS_VEC_TX_PERF_EN
   logic [31:0] cycles_q;

   always_ff @(posedge aclk) begin
      if (areset) begin
         cycles_q <= '0;
      end else if (start_ok) begin
         cycles_q <= '0;
      end else if ((state_q == S_SEND) && (cycles_q != 32'hFFFF_FFFF)) begin
         cycles_q <= cycles_q + 32'd1;
      end
   end

   assign cycles = cycles_q;
`else
   assign cycles = 32'h0;
`endif

endmodule

// File: tb/tb_axis_vec_tx.sv
// Directed self-checking bench for axis_vec_tx; expectations follow AXIS_VEC_TX_PERF_EN when defined.
module tb_axis_vec_tx;
   import axis_vec_pkg::*;

   localparam int unsigned DEPTH = 20;

`ifdef AXIS_VEC_TX_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        aclk = 1'b0;
   logic        areset;
   logic        wr_en;
   logic [4:0]  wr_addr;
   word_t       wr_data;
   logic [5:0]  len;
   logic        start;
   logic        busy;
   logic        done;
   logic        start_err;
   logic [31:0] cycles;
   word_t       tdata;
   logic        tlast;
   logic        tvalid;
   logic        tready;

   int    n_checks = 0;
   int    n_err    = 0;
   word_t w [DEPTH];
   word_t w0_orig;

   axis_vec_tx #(
      .DEPTH (DEPTH)
   ) dut (
      .aclk               (aclk),
      .areset             (areset),
      .wr_en              (wr_en),
      .wr_addr            (wr_addr),
      .wr_data            (wr_data),
      .len                (len),
      .start              (start),
      .busy               (busy),
      .done               (done),
      .start_err          (start_err),
      .cycles             (cycles),
      .OUTPUT_AXIS_TDATA  (tdata),
      .OUTPUT_AXIS_TLAST  (tlast),
      .OUTPUT_AXIS_TVALID (tvalid),
      .OUTPUT_AXIS_TREADY (tready)
   );

   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge aclk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int a, input word_t d);
      wr_en   = 1'b1;
      wr_addr = a[4:0];
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic launch(input int n);
      len   = n[5:0];
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Called in the first TVALID cycle; drives TREADY and checks every cycle up to idle.
   task automatic stream(input int n, input bit alt, input string tag);
      int beat = 0;
      int k    = 0;
      while (beat < n && k < 200) begin
         tready = alt ? (k % 2 == 0) : 1'b1;
         chk({tag, "_tvalid"}, tvalid, 1);
         chk({tag, "_tdata"}, tdata, w[beat]);
         chk({tag, "_tlast"}, tlast, (beat == n - 1));
         chk({tag, "_busy"}, busy, 1);
         tick();
         if (tready) beat++;
         k++;
      end
      chk({tag, "_beats"}, beat, n);
      chk({tag, "_span"}, k, alt ? 2 * n - 1 : n);
      chk({tag, "_done_tvalid"}, tvalid, 0);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_cycles"}, cycles, PERF ? k : 0);
      tick();
      chk({tag, "_done_off"}, done, 0);
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_cycles_hold"}, cycles, PERF ? k : 0);
   endtask

   initial begin
      areset  = 1'b1;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      len     = '0;
      start   = 1'b0;
      tready  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         w[i] = 32'h3F7F_CC9A ^ word_t'(i * 32'h0123_4567);
      end
      w0_orig = w[0];

      // Reset held 20 cycles
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("rst_tvalid", tvalid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_cycles", cycles, 0);
      end
      chk("rst_tdata", tdata, 0);
      chk("rst_tlast", tlast, 0);
      chk("rst_start_err", start_err, 0);
      areset = 1'b0;

      for (int i = 0; i < DEPTH; i++) wr(i, w[i]);

      // Full packet, TREADY held high
      tready = 1'b1;
      launch(20);
      stream(20, 1'b0, "full");

      // Full packet, TREADY alternating 1,0 from first TVALID
      tready = 1'b0;
      launch(20);
      stream(20, 1'b1, "alt");

      // Single beat; write to buf[0] in the same cycle as the start
      w[0]    = 32'h3F80_0000;
      wr_en   = 1'b1;
      wr_addr = 5'd0;
      wr_data = 32'h3F80_0000;
      len     = 6'd1;
      start   = 1'b1;
      tick();
      wr_en   = 1'b0;
      start   = 1'b0;
      stream(1, 1'b0, "single");

      // Rejected starts
      launch(0);
      chk("len0_err", start_err, 1);
      chk("len0_tvalid", tvalid, 0);
      chk("len0_busy", busy, 0);
      tick();
      chk("len0_err_once", start_err, 0);
      launch(21);
      chk("len21_err", start_err, 1);
      chk("len21_tvalid", tvalid, 0);
      chk("len21_busy", busy, 0);
      tick();
      chk("len21_err_once", start_err, 0);
      chk("len21_busy_after", busy, 0);

      // Restore buf[0], then reset after 5 beats; write while busy must be dropped
      w[0] = w0_orig;
      wr(0, w0_orig);
      tready = 1'b1;
      launch(20);
      for (int b = 0; b < 5; b++) begin
         chk("abort_tdata", tdata, w[b]);
         if (b == 2) begin
            wr_en   = 1'b1;
            wr_addr = 5'd3;
            wr_data = 32'hDEAD_BEEF;
         end
         tick();
         wr_en = 1'b0;
      end
      chk("abort_pre_tdata", tdata, w[5]);
      areset = 1'b1;
      tick();
      areset = 1'b0;
      chk("abort_tvalid", tvalid, 0);
      chk("abort_tlast", tlast, 0);
      chk("abort_busy", busy, 0);
      chk("abort_cycles", cycles, 0);
      launch(20);
      stream(20, 1'b0, "restart");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
